// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: req/ack handshake to a variable-latency bus, pipeline stall.
// Optional posted write buffer enabled by defining DMEM_WRITE_BUFFER_EN.
module dmem_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_m,
  input  logic              memwrite_m,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              stall_m,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef DMEM_WRITE_BUFFER_EN
  localparam logic [1:0] DRAIN = 2'd3;
`endif

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic              stall;
  logic              access, is_store, aligned, timeout;

`ifdef DMEM_WRITE_BUFFER_EN
  // Buffer contents live in the bus address/data registers while the write drains.
  logic              wb_valid_q, wb_valid_d;
`endif

  assign access   = memread_m | memwrite_m;
  assign is_store = memwrite_m;
  assign aligned  = (ALUOutM[1:0] == 2'b00);
  assign timeout  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    stall   = 1'b0;
`ifdef DMEM_WRITE_BUFFER_EN
    wb_valid_d = wb_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (!aligned) begin
            mis_d   = 1'b1;
            state_d = DONE;
            if (!is_store) rdata_d = 32'd0;
          end else begin
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
            wdata_d = WriteDataM;
            cnt_d   = '0;
            state_d = REQ;
`ifdef DMEM_WRITE_BUFFER_EN
            if (is_store && !wb_valid_q) begin
              stall      = 1'b0;
              wb_valid_d = 1'b1;
              state_d    = DRAIN;
            end
`endif
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if (timeout) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
`ifdef DMEM_WRITE_BUFFER_EN
      DRAIN: begin
        // A new access waits for the posted write, then restarts from IDLE.
        stall = access;
        if (mem_ack || timeout) begin
          req_d      = 1'b0;
          berr_d     = !mem_ack;
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

`ifdef DMEM_WRITE_BUFFER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_valid_q <= 1'b0;
    else       wb_valid_q <= wb_valid_d;
  end
`endif

  // Reset gates the combinational stall so a held request cannot freeze the pipe.
  assign stall_m      = stall & ~reset;
  assign ReadDataM    = rdata_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl (default build, TIMEOUT_CYCLES=4).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread_m = 1'b0, memwrite_m = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        stall_m, misalign_err, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .memread_m   (memread_m),
    .memwrite_m  (memwrite_m),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .ReadDataM   (ReadDataM),
    .stall_m     (stall_m),
    .misalign_err(misalign_err),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;     // REQ cycle carrying mem_ack; 0 = never
    int          exp_stall;
    int          exp_req;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [31:0] exp_rdm;
    bit          exp_mis;
    bit          exp_berr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int  stalls = 0;
    int  reqs   = 0;
    bit  done   = 0;
    @(negedge clk);
    memread_m  = v.rd;
    memwrite_m = v.wr;
    ALUOutM    = v.addr;
    WriteDataM = v.wdata;
    mem_rdata  = v.rdata;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (stall_m) begin
        stalls++;
        if (mem_req) begin
          reqs++;
          if (reqs == 1) begin
            check($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
            check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.exp_we});
            if (v.exp_we) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
          end
          if (reqs == v.ack_at) mem_ack = 1'b1;
        end
      end else begin
        done = 1;
        check($sformatf("v%0d ReadDataM", idx), ReadDataM, v.exp_rdm);
        check($sformatf("v%0d misalign_err", idx), {31'd0, misalign_err}, {31'd0, v.exp_mis});
        check($sformatf("v%0d bus_err", idx), {31'd0, bus_err}, {31'd0, v.exp_berr});
        check($sformatf("v%0d mem_req in done", idx), {31'd0, mem_req}, 32'd0);
      end
    end
    if (!done) check($sformatf("v%0d completion within bound", idx), 32'd0, 32'd1);
    check($sformatf("v%0d stall cycles", idx), 32'(stalls), 32'(v.exp_stall));
    check($sformatf("v%0d req cycles", idx), 32'(reqs), 32'(v.exp_req));
    memread_m  = 1'b0;
    memwrite_m = 1'b0;
    mem_ack    = 1'b0;
    @(negedge clk);
    #1;
    check($sformatf("v%0d err pulse cleared", idx), {30'd0, misalign_err, bus_err}, 32'd0);
    check($sformatf("v%0d idle stall", idx), {31'd0, stall_m}, 32'd0);
    check($sformatf("v%0d ReadDataM held", idx), ReadDataM, v.exp_rdm);
  endtask

  initial begin
    //          rd wr addr          wdata         rdata         ack stl req exp_addr     we rdm           mis berr
    vecs[0] = '{1, 0, 32'h100,      32'h0,        32'hDEADBEEF, 1,  2,  1,  32'h100,      0, 32'hDEADBEEF, 0, 0};
    vecs[1] = '{0, 1, 32'h204,      32'h12345678, 32'h0,        4,  5,  4,  32'h204,      1, 32'hDEADBEEF, 0, 0};
    vecs[2] = '{1, 0, 32'h101,      32'h0,        32'h77777777, 0,  1,  0,  32'h0,        0, 32'h0,        1, 0};
    vecs[3] = '{1, 0, 32'h40,       32'h0,        32'hCAFEF00D, 2,  3,  2,  32'h40,       0, 32'hCAFEF00D, 0, 0};
    vecs[4] = '{0, 1, 32'h206,      32'h99999999, 32'h0,        0,  1,  0,  32'h0,        1, 32'hCAFEF00D, 1, 0};
    vecs[5] = '{1, 1, 32'h8,        32'hA5A5A5A5, 32'h11111111, 1,  2,  1,  32'h8,        1, 32'hCAFEF00D, 0, 0};
    vecs[6] = '{1, 0, 32'h300,      32'h0,        32'hBAD0BAD0, 0,  5,  4,  32'h300,      0, 32'h0,        0, 1};
    vecs[7] = '{1, 0, 32'hFFFFFFFC, 32'h0,        32'h13579BDF, 3,  4,  3,  32'hFFFFFFFC, 0, 32'h13579BDF, 0, 0};
    vecs[8] = '{0, 1, 32'h10,       32'h0F0F0F0F, 32'h0,        0,  5,  4,  32'h10,       1, 32'h13579BDF, 0, 1};

    #12;
    check("reset mem_req/we", {30'd0, mem_req, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset ReadDataM", ReadDataM, 32'd0);
    check("reset stall/errs", {29'd0, stall_m, misalign_err, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run(vecs[i], i);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("idle ack mem_req", {31'd0, mem_req}, 32'd0);
    check("idle ack ReadDataM", ReadDataM, 32'h13579BDF);
    check("idle ack stall", {31'd0, stall_m}, 32'd0);

    // Reset in the middle of a REQ phase.
    @(negedge clk);
    memread_m = 1'b1;
    ALUOutM   = 32'h80;
    @(negedge clk);
    #1;
    check("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    check("pre-reset stall", {31'd0, stall_m}, 32'd1);
    reset = 1'b1;
    #1;
    check("async reset mem_req", {31'd0, mem_req}, 32'd0);
    check("async reset stall", {31'd0, stall_m}, 32'd0);
    check("async reset ReadDataM", ReadDataM, 32'd0);
    memread_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run(vecs[0], 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
